// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side serializer: state encoding and index sizing.
package fifo_rd_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } rd_state_e;

    // Slice index width; a single-slice word still needs one bit to hold index 0.
    function automatic int unsigned idx_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_serializer.sv
// Pops wide words from a show-ahead FIFO and emits them LSB-first as OUT_WIDTH slices
// on a valid/ready stream, counting fully transmitted words.
module fifo_rd_serializer
    import fifo_rd_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 64,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_dout,
    output logic                 fifo_pop,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic [15:0]          words_done
);

    localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned IDX_W = idx_width(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if (OUT_WIDTH > IN_WIDTH || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_width
        $error("IN_WIDTH must be a non-zero integer multiple of OUT_WIDTH");
    end

    rd_state_e             state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IN_WIDTH-1:0]   word_q, word_d;
    logic [15:0]           words_done_q, words_done_d;

    logic                  valid_w;
    logic                  at_last_w;
    logic                  handshake_w;
    logic                  pop_w;

    // State register; the held word is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            words_done_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            words_done_q <= words_done_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    // Next-state logic: flush dominates, a pop reloads even on the last-slice handshake.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        word_d       = word_q;
        words_done_d = words_done_q;
        if (flush) begin
            state_d = StIdle;
            idx_d   = '0;
        end else begin
            if (handshake_w) begin
                if (at_last_w) begin
                    words_done_d = words_done_q + 16'd1;
                    state_d      = StIdle;
                    idx_d        = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            if (pop_w) begin
                word_d  = fifo_dout;
                idx_d   = '0;
                state_d = StSend;
            end
        end
    end

    // Output logic.
    always_comb begin
        valid_w     = (state_q == StSend);
        at_last_w   = (idx_q == LAST_IDX);
        handshake_w = valid_w && out_ready;
        pop_w       = !rst && !fifo_empty && !flush &&
                      ((state_q == StIdle) || (handshake_w && at_last_w));
    end

    assign fifo_pop   = pop_w;
    assign out_valid  = valid_w;
    assign out_last   = valid_w && at_last_w;
    assign out_data   = word_q[int'(idx_q) * OUT_WIDTH +: OUT_WIDTH];
    assign words_done = words_done_q;

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Self-checking bench: slice-queue reference model for the 64/16 serializer plus a
// single-slice instance driven long enough to wrap the word counter.
module tb_fifo_rd_serializer;

    localparam int unsigned IW = 64;
    localparam int unsigned OW = 16;
    localparam int unsigned R  = IW / OW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, fifo_empty, fifo_pop, flush, out_valid, out_ready, out_last;
    logic [IW-1:0] fifo_dout;
    logic [OW-1:0] out_data;
    logic [15:0]   words_done;

    logic          rst2, empty2, pop2, valid2, last2;
    logic [63:0]   dout2, data2;
    logic [15:0]   done2;
    logic          flush2 = 1'b0;
    logic          ready2 = 1'b1;

    fifo_rd_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_pop   (fifo_pop),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .words_done (words_done)
    );

    fifo_rd_serializer #(.IN_WIDTH(64), .OUT_WIDTH(64)) u_dut_r1 (
        .clk        (clk),
        .rst        (rst2),
        .fifo_empty (empty2),
        .fifo_dout  (dout2),
        .fifo_pop   (pop2),
        .flush      (flush2),
        .out_valid  (valid2),
        .out_ready  (ready2),
        .out_data   (data2),
        .out_last   (last2),
        .words_done (done2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream FIFO contents and the reference model: remaining slices of the held word.
    logic [IW-1:0] fifo_q[$];
    logic [OW-1:0] sl_q[$];
    logic [15:0]   m_done;

    logic          last_pop, last_valid, last_last;
    logic [OW-1:0] last_data;
    logic [15:0]   last_done;
    bit            r1_done = 1'b0;

    function automatic void refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? '0 : fifo_q[0];
    endfunction

    function automatic void push_word(input logic [IW-1:0] w);
        fifo_q.push_back(w);
        refresh();
    endfunction

    // One clock cycle: compare at the falling edge, advance model, retire FIFO pop.
    task automatic cycle();
        logic          e_valid, e_last, e_pop;
        logic [OW-1:0] e_data;
        logic [IW-1:0] w;
        @(negedge clk);
        e_valid = (sl_q.size() > 0);
        e_last  = (sl_q.size() == 1);
        e_data  = e_valid ? sl_q[0] : '0;
        e_pop   = !rst && (fifo_q.size() > 0) && !flush && (!e_valid || (out_ready && e_last));
        last_pop   = fifo_pop;
        last_valid = out_valid;
        last_last  = out_last;
        last_data  = out_data;
        last_done  = words_done;
        chk("fifo_pop", fifo_pop, e_pop);
        chk("out_valid", out_valid, e_valid);
        chk("words_done", words_done, m_done);
        if (e_valid) begin
            chk("out_data", out_data, e_data);
            chk("out_last", out_last, e_last);
        end
        if (rst) begin
            sl_q.delete();
            m_done = '0;
        end else if (flush) begin
            sl_q.delete();
        end else begin
            if (e_valid && out_ready) begin
                void'(sl_q.pop_front());
                if (e_last) m_done = m_done + 16'd1;
            end
            if (e_pop) begin
                w = fifo_q[0];
                for (int k = 0; k < R; k++) sl_q.push_back(w[k*OW +: OW]);
            end
        end
        @(posedge clk);
        #1;
        if (last_pop === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh();
    endtask

    initial begin
        logic [15:0]   exp34 [4];
        logic [IW-1:0] wa, wb;
        logic [OW-1:0] acc[$];
        logic [15:0]   d0;
        int            pop_mask, vcnt, vfirst, vlast;
        logic          rdy;

        exp34[0] = 16'h1111; exp34[1] = 16'h2222; exp34[2] = 16'h3333; exp34[3] = 16'h4444;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        refresh();
        repeat (2) @(posedge clk);
        #1;
        sl_q.delete();
        m_done = '0;

        // Reset holds pop low even with a word waiting.
        push_word(64'h4444_3333_2222_1111);
        cycle();
        chk("rst_pop", last_pop, 1'b0);
        chk("rst_valid", last_valid, 1'b0);
        chk("rst_done", last_done, 16'd0);

        // Single word.
        rst = 1'b0; out_ready = 1'b1;
        cycle();
        chk("single_pop", last_pop, 1'b1);
        chk("single_idle_valid", last_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("single_valid", last_valid, 1'b1);
            chk("single_data", last_data, exp34[k]);
            chk("single_last", last_last, k == 3);
        end
        cycle();
        chk("single_end_valid", last_valid, 1'b0);
        chk("single_end_pop", last_pop, 1'b0);
        chk("single_end_done", last_done, 16'd1);

        // Back-to-back three words.
        for (int k = 0; k < 3; k++) push_word({$urandom, $urandom});
        pop_mask = 0; vcnt = 0; vfirst = -1; vlast = -1;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (last_pop) pop_mask |= (1 << i);
            if (last_valid) begin
                vcnt++;
                if (vfirst < 0) vfirst = i;
                vlast = i;
            end
        end
        chk("b2b_pops", pop_mask, 32'h111);
        chk("b2b_valid_cnt", vcnt, 12);
        chk("b2b_valid_span", vlast - vfirst + 1, 12);
        chk("b2b_done", last_done, 16'd4);

        // Backpressure 1,0,0 pattern.
        wa = {$urandom, $urandom};
        push_word(wa);
        for (int i = 0; i < 40 && acc.size() < 4; i++) begin
            out_ready = (i % 3 == 0);
            rdy = out_ready;
            cycle();
            if (last_valid && rdy) acc.push_back(last_data);
        end
        chk("bp_count", acc.size(), 4);
        for (int k = 0; k < 4 && k < acc.size(); k++)
            chk("bp_slice", acc[k], (wa >> (16 * k)) & 64'hFFFF);
        out_ready = 1'b1;
        repeat (2) cycle();

        // Flush at idx 2.
        wa = {$urandom, $urandom};
        wb = {$urandom, $urandom};
        push_word(wa);
        push_word(wb);
        repeat (3) cycle();
        d0 = last_done;
        flush = 1'b1;
        cycle();
        chk("flush_slice2", last_data, wa[47:32]);
        chk("flush_no_pop", last_pop, 1'b0);
        flush = 1'b0;
        cycle();
        chk("flush_valid", last_valid, 1'b0);
        chk("flush_repop", last_pop, 1'b1);
        chk("flush_done", last_done, d0);
        cycle();
        chk("flush_restart", last_data, wb[15:0]);
        repeat (5) cycle();

        // Reset mid-word at idx 1.
        push_word({$urandom, $urandom});
        push_word({$urandom, $urandom});
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        chk("rstmid_pop", last_pop, 1'b0);
        rst = 1'b0;
        cycle();
        chk("rstmid_valid", last_valid, 1'b0);
        chk("rstmid_done", last_done, 16'd0);
        repeat (6) cycle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 199) < 1);
            if ($urandom_range(0, 99) < 40 && fifo_q.size() < 6) push_word({$urandom, $urandom});
            cycle();
        end
        rst = 1'b0; flush = 1'b0;

        for (int i = 0; i < 100000 && !r1_done; i++) @(posedge clk);
        chk("r1_finished", r1_done, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Single-slice instance: every accepted slice completes a word; run past the 16-bit wrap.
    initial begin
        int          hs_total, cyc;
        logic        e_v2, e_pop2;
        logic [15:0] e_cnt2;
        logic [63:0] e_d2;
        rst2 = 1'b1; empty2 = 1'b1; dout2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst2 = 1'b0;
        e_v2 = 1'b0; e_cnt2 = '0; e_d2 = '0; hs_total = 0; cyc = 0;
        while (hs_total < 65538 && cyc < 70000) begin
            empty2 = (cyc < 300) ? ($urandom_range(0, 1) == 0) : 1'b0;
            dout2  = {$urandom, $urandom};
            @(negedge clk);
            e_pop2 = !empty2;
            chk("r1_pop", pop2, e_pop2);
            chk("r1_valid", valid2, e_v2);
            chk("r1_done", done2, e_cnt2);
            if (e_v2) begin
                chk("r1_data", data2, e_d2);
                chk("r1_last", last2, 1'b1);
            end
            if (hs_total == 65535) chk("r1_wrap_ffff", done2, 16'hFFFF);
            if (hs_total == 65536) chk("r1_wrap_zero", done2, 16'h0000);
            if (e_v2) begin
                e_cnt2 = e_cnt2 + 16'd1;
                hs_total++;
            end
            e_v2 = e_pop2;
            e_d2 = dout2;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("r1_words", hs_total >= 65538, 1'b1);
        r1_done = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/fifo_rd_serializer.md
FIFO_RD_SERIALIZER -- requirements
Module: fifo_rd_serializer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 64: width of words read from the upstream FIFO.
REQ-002 SHALL have parameter OUT_WIDTH, default 16: width of each emitted slice; IN_WIDTH SHALL be an integer multiple of OUT_WIDTH (RATIO = IN_WIDTH/OUT_WIDTH >= 1).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port fifo_empty, input, 1: upstream FIFO empty flag.
REQ-006 SHALL have port fifo_dout, input, IN_WIDTH: upstream FIFO head word, valid combinationally while fifo_empty=0 (show-ahead).
REQ-007 SHALL have port fifo_pop, output, 1: pop strobe to the upstream FIFO.
REQ-008 SHALL have port flush, input, 1: discard the held word and return to idle.
REQ-009 SHALL have port out_valid, output, 1: out_data/out_last valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the slice.
REQ-011 SHALL have port out_data, output, OUT_WIDTH: current slice.
REQ-012 SHALL have port out_last, output, 1: current slice is the final slice of its word.
REQ-013 SHALL have port words_done, output, 16: count of fully transmitted words, wraps modulo 2^16.

Function
REQ-014 SHALL implement the states IDLE (no word held, out_valid=0) and SEND (word held, out_valid=1).
REQ-015 SHALL drive fifo_pop combinationally = !fifo_empty && !flush && (state==IDLE || (out_valid && out_ready && out_last)).
REQ-016 SHALL never assert fifo_pop while fifo_empty=1.
REQ-017 SHALL, on each fifo_pop cycle, capture fifo_dout into the word register, set slice index to 0, and enter or remain in SEND.
REQ-018 SHALL deliver the first slice with latency 1: a word popped in cycle n produces out_valid=1 in cycle n+1.
REQ-019 SHALL emit slices LSB first: out_data = word[idx*OUT_WIDTH +: OUT_WIDTH], idx 0..RATIO-1.
REQ-020 SHALL assert out_last exactly when idx==RATIO-1; with RATIO=1, every slice is last.
REQ-021 SHALL advance idx only on handshake (out_valid && out_ready); while out_ready=0, out_data, out_last and idx SHALL hold stable.
REQ-022 SHALL, on a last-slice handshake with fifo_empty=1, go to IDLE with out_valid=0 the next cycle.
REQ-023 SHALL, on a last-slice handshake with fifo_empty=0, pop and load the next word in the same cycle, with no bubble (sustained one slice per cycle).
REQ-024 SHALL increment words_done by 1 on every last-slice handshake.
REQ-025 SHALL, on flush=1, go to IDLE, clear idx, drop out_valid the next cycle, not pop, and not increment words_done; flush has priority over a same-cycle handshake.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set state=IDLE, idx=0, out_valid=0, words_done=0.
REQ-027 SHALL hold fifo_pop=0 while rst=1.
REQ-028 SHALL leave the word register unreset; out_data is don't-care while out_valid=0.
REQ-029 SHALL, on reset mid-word, discard the remaining slices; the FIFO's own reset is independent.

Structure
REQ-030 SHALL place the state enum (IDLE, SEND) in shared package fifo_rd_pkg.
REQ-031 SHALL elaborate-time assert IN_WIDTH % OUT_WIDTH == 0 and OUT_WIDTH <= IN_WIDTH.
REQ-032 SHALL size idx as max(1,$clog2(RATIO)) bits.
REQ-033 SHALL contain no sub-module; the generic synchronous FIFO is instantiated alongside by the parent and connected via fifo_empty, fifo_dout and fifo_pop.

Verification
REQ-034 Single word: FIFO holds 0x4444_3333_2222_1111, out_ready=1 -> pop in cycle n; slices 0x1111, 0x2222, 0x3333, 0x4444 in cycles n+1..n+4; out_last only at n+4; words_done=1; IDLE at n+5.
REQ-035 Back-to-back: 3 words queued, out_ready=1 -> 12 consecutive valid cycles, no bubble; fifo_pop pulses at n, n+4 and n+8; words_done=3.
REQ-036 Backpressure: out_ready toggled 1,0,0,1,... -> each slice held stable under out_ready=0; no slice skipped or duplicated; pop only after the last-slice handshake.
REQ-037 Flush: flush=1 while idx=2 -> out_valid=0 next cycle; words_done unchanged; next queued word restarts at slice 0.
REQ-038 Reset mid-word: rst=1 at idx=1 -> out_valid=0, words_done=0, fifo_pop=0 during reset.
REQ-039 RATIO=1 (OUT_WIDTH=64) with empty FIFO -> fifo_pop never asserts while fifo_empty=1; counter wraps 0xFFFF->0x0000 after 65536 words.
